// File: rtl/acp_wr_dma.sv
// rtl/acp_wr_dma.sv - AXI3 ACP write DMA: 64-bit stream into DDR in 4 KB-safe INCR bursts.
// Optional ACP_WR_PERF_CNT_EN adds a busy-to-done cycle counter (perf_cycles).
module acp_wr_dma #(
    parameter int         FIFO_DEPTH = 32,
    parameter logic [2:0] AXI_ID     = 3'd0,
    parameter int         MAX_BURST  = 16
) (
    input  logic        FCLK_CLK0_0,
    input  logic        FCLK_RESET0_N_0,
    input  logic        cfg_start,
    input  logic [31:0] cfg_base,
    input  logic [15:0] cfg_beats,
    output logic        busy,
    output logic        done,
    output logic        err,
`ifdef ACP_WR_PERF_CNT_EN
    output logic [31:0] perf_cycles,
`endif
    input  logic [63:0] s_tdata,
    input  logic        s_tvalid,
    output logic        s_tready,
    output logic [31:0] m_awaddr,
    output logic [3:0]  m_awlen,
    output logic [2:0]  m_awsize,
    output logic [1:0]  m_awburst,
    output logic [3:0]  m_awcache,
    output logic [2:0]  m_awprot,
    output logic [4:0]  m_awuser,
    output logic [2:0]  m_awid,
    output logic        m_awvalid,
    input  logic        m_awready,
    output logic [63:0] m_wdata,
    output logic [7:0]  m_wstrb,
    output logic        m_wlast,
    output logic [2:0]  m_wid,
    output logic        m_wvalid,
    input  logic        m_wready,
    input  logic [1:0]  m_bresp,
    input  logic        m_bvalid,
    output logic        m_bready
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_AW, S_W, S_B, S_DONE} state_t;
    state_t state;

    logic [63:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] fifo_count;
    logic [31:0]   addr;
    logic [15:0]   rem, total, acc_cnt;
    logic [4:0]    burst_n, wcnt;
    logic [15:0]   to_4k, n_cap, n_next;
    logic          push, pop, fifo_full;
    logic          unused_ok;

    assign m_awsize  = 3'b011;
    assign m_awburst = 2'b01;
    assign m_awcache = 4'b1111;
    assign m_awuser  = 5'b11111;
    assign m_awprot  = 3'b000;
    assign m_wstrb   = 8'hFF;
    assign m_awid    = AXI_ID;
    assign m_wid     = AXI_ID;
    assign unused_ok = ^cfg_base[2:0];

    assign fifo_full = (fifo_count == CW'(FIFO_DEPTH));
    assign s_tready  = busy && !fifo_full && (acc_cnt < total);
    assign push      = s_tvalid && s_tready;
    assign m_wvalid  = (state == S_W) && (fifo_count != '0);
    assign pop       = m_wvalid && m_wready;
    assign m_wdata   = mem[rd_ptr];
    assign m_wlast   = (state == S_W) && (wcnt == burst_n - 5'd1);
    assign m_bready  = (state == S_B);

    // Burst length: limited by remaining beats, AXI3 max and the next 4 KB page edge.
    assign to_4k  = 16'd512 - {7'd0, addr[11:3]};
    assign n_cap  = (rem > 16'(MAX_BURST)) ? 16'(MAX_BURST) : rem;
    assign n_next = (n_cap > to_4k) ? to_4k : n_cap;

    always_ff @(posedge FCLK_CLK0_0) begin
        if (push) mem[wr_ptr] <= s_tdata;
    end

    always_ff @(posedge FCLK_CLK0_0 or negedge FCLK_RESET0_N_0) begin
        if (!FCLK_RESET0_N_0) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            acc_cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr  <= wr_ptr + 1'b1;
                acc_cnt <= acc_cnt + 16'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      fifo_count <= fifo_count + 1'b1;
            else if (pop && !push) fifo_count <= fifo_count - 1'b1;
            if (cfg_start && state == S_IDLE) acc_cnt <= '0;
        end
    end

    always_ff @(posedge FCLK_CLK0_0 or negedge FCLK_RESET0_N_0) begin
        if (!FCLK_RESET0_N_0) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            m_awvalid <= 1'b0;
            m_awaddr  <= '0;
            m_awlen   <= '0;
            addr      <= '0;
            rem       <= '0;
            total     <= '0;
            burst_n   <= '0;
            wcnt      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (cfg_start) begin
                    err   <= 1'b0;
                    addr  <= {cfg_base[31:3], 3'b000};
                    rem   <= cfg_beats;
                    total <= cfg_beats;
                    if (cfg_beats == 16'd0) begin
                        done <= 1'b1;
                    end else begin
                        busy  <= 1'b1;
                        state <= S_FILL;
                    end
                end
                // Holding AW until the whole burst is buffered keeps W from starving.
                S_FILL: if (16'(fifo_count) >= n_next) begin
                    m_awaddr  <= addr;
                    m_awlen   <= 4'(n_next - 16'd1);
                    burst_n   <= 5'(n_next);
                    m_awvalid <= 1'b1;
                    state     <= S_AW;
                end
                S_AW: if (m_awready) begin
                    m_awvalid <= 1'b0;
                    wcnt      <= '0;
                    state     <= S_W;
                end
                S_W: if (pop) begin
                    wcnt <= wcnt + 5'd1;
                    if (wcnt == burst_n - 5'd1) state <= S_B;
                end
                S_B: if (m_bvalid) begin
                    if (m_bresp != 2'b00) err <= 1'b1;
                    addr <= addr + {24'd0, burst_n, 3'b000};
                    rem  <= rem - {11'd0, burst_n};
                    state <= (rem == {11'd0, burst_n}) ? S_DONE : S_FILL;
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef ACP_WR_PERF_CNT_EN
    always_ff @(posedge FCLK_CLK0_0 or negedge FCLK_RESET0_N_0) begin
        if (!FCLK_RESET0_N_0)
            perf_cycles <= '0;
        else if (cfg_start && state == S_IDLE)
            perf_cycles <= '0;
        else if ((busy || done) && perf_cycles != 32'hFFFF_FFFF)
            perf_cycles <= perf_cycles + 32'd1;
    end
`endif
endmodule

// File: tb/tb_acp_wr_dma.sv
// tb/tb_acp_wr_dma.sv - scoreboard bench for acp_wr_dma with an AXI3 slave/DDR model.
module tb_acp_wr_dma;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_start = 1'b0;
    logic [31:0] cfg_base = '0;
    logic [15:0] cfg_beats = '0;
    logic        busy, done, err;
    logic [63:0] s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [31:0] m_awaddr;
    logic [3:0]  m_awlen, m_awcache;
    logic [2:0]  m_awsize, m_awprot, m_awid, m_wid;
    logic [1:0]  m_awburst;
    logic [4:0]  m_awuser;
    logic        m_awvalid, m_wlast, m_wvalid, m_bready;
    logic        m_awready = 1'b0;
    logic        m_wready = 1'b0;
    logic [63:0] m_wdata;
    logic [7:0]  m_wstrb;
    logic [1:0]  m_bresp = 2'b00;
    logic        m_bvalid = 1'b0;
`ifdef ACP_WR_PERF_CNT_EN
    logic [31:0] perf_cycles;
    int          meas_cnt = 0;
    always @(posedge clk) if (busy || done) meas_cnt++;
`endif

    always #5 clk = ~clk;

    acp_wr_dma dut (
        .FCLK_CLK0_0(clk), .FCLK_RESET0_N_0(rst_n),
        .cfg_start(cfg_start), .cfg_base(cfg_base), .cfg_beats(cfg_beats),
        .busy(busy), .done(done), .err(err),
`ifdef ACP_WR_PERF_CNT_EN
        .perf_cycles(perf_cycles),
`endif
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
        .m_awcache(m_awcache), .m_awprot(m_awprot), .m_awuser(m_awuser), .m_awid(m_awid),
        .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wid(m_wid),
        .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
    );

    int total = 0;
    int bad = 0;
    int rmode = 0;
    logic [63:0] src[$];
    logic [63:0] exp_w[$];
    logic [31:0] exp_aw_addr[$];
    int          exp_aw_n[$];
    logic [1:0]  bresp_plan[$];
    logic [63:0] ddr [logic [31:0]];

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic rdelay();
        if (rmode != 0) repeat ($urandom_range(0, 7)) @(negedge clk);
    endtask

    task automatic start_pulse(input logic [31:0] base, input logic [15:0] beats);
        cfg_base = base; cfg_beats = beats; cfg_start = 1'b1;
`ifdef ACP_WR_PERF_CNT_EN
        meas_cnt = 0;
`endif
        @(negedge clk);
        cfg_start = 1'b0;
    endtask

    task automatic plan(input logic [31:0] base, input int beats, input int bad_idx);
        logic [31:0] a;
        int r, n, b4k, k;
        a = {base[31:3], 3'b000}; r = beats; k = 0;
        while (r > 0) begin
            n = (r > 16) ? 16 : r;
            b4k = (4096 - int'(a[11:0])) / 8;
            if (n > b4k) n = b4k;
            exp_aw_addr.push_back(a);
            exp_aw_n.push_back(n);
            bresp_plan.push_back((k == bad_idx) ? 2'b10 : 2'b00);
            a = a + 32'(8 * n); r = r - n; k++;
        end
        for (int i = 0; i < beats; i++) begin
            logic [63:0] d;
            d = {$urandom, $urandom};
            src.push_back(d);
            exp_w.push_back(d);
        end
    endtask

    task automatic drive_stream(input int beats);
        int idx, cyc;
        idx = 0; cyc = 0;
        while (idx < beats && cyc < 4000) begin
            s_tdata = src[idx];
            s_tvalid = (rmode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (s_tvalid && s_tready) idx++;
            @(negedge clk);
            cyc++;
        end
        s_tvalid = 1'b0;
        if (idx < beats) begin
            total++; bad++;
            $display("FAIL stream_timeout: accepted=%0d required=%0d", idx, beats);
        end
    endtask

    task automatic run_slave(input int nb);
        for (int k = 0; k < nb; k++) begin
            logic [31:0] ea, oa;
            int en, cyc;
            logic [63:0] ew;
            ea = exp_aw_addr.pop_front(); en = exp_aw_n.pop_front();
            rdelay();
            m_awready = 1'b1; cyc = 0;
            while (!m_awvalid && cyc < 2000) begin @(negedge clk); cyc++; end
            if (!m_awvalid) begin
                total++; bad++; m_awready = 1'b0;
                $display("FAIL aw_timeout: burst=%0d", k);
                return;
            end
            total++;
            if (m_awaddr !== ea || m_awlen !== 4'(en - 1) || m_wvalid !== 1'b0) begin
                bad++;
                $display("FAIL aw_burst%0d: addr=%h len=%0d wvalid=%b required addr=%h len=%0d wvalid=0",
                         k, m_awaddr, m_awlen, m_wvalid, ea, en - 1);
            end
            oa = m_awaddr;
            @(negedge clk);
            m_awready = 1'b0;
            for (int j = 0; j < en; j++) begin
                rdelay();
                m_wready = 1'b1; cyc = 0;
                while (!m_wvalid && cyc < 2000) begin @(negedge clk); cyc++; end
                if (!m_wvalid) begin
                    total++; bad++; m_wready = 1'b0;
                    $display("FAIL w_timeout: burst=%0d beat=%0d", k, j);
                    return;
                end
                ew = exp_w.pop_front();
                total++;
                if (m_wdata !== ew || m_wlast !== (j == en - 1) || m_awvalid !== 1'b0) begin
                    bad++;
                    $display("FAIL w_beat b%0d/%0d: data=%h last=%b awvalid=%b required data=%h last=%b awvalid=0",
                             k, j, m_wdata, m_wlast, m_awvalid, ew, (j == en - 1));
                end
                ddr[oa + 32'(8 * j)] = m_wdata;
                @(negedge clk);
                m_wready = 1'b0;
            end
            rdelay();
            m_bvalid = 1'b1; m_bresp = bresp_plan.pop_front(); cyc = 0;
            while (!m_bready && cyc < 2000) begin @(negedge clk); cyc++; end
            if (!m_bready) begin
                total++; bad++;
                $display("FAIL b_timeout: burst=%0d", k);
            end
            @(negedge clk);
            m_bvalid = 1'b0; m_bresp = 2'b00;
        end
    endtask

    task automatic wait_done(input logic exp_err);
        int cyc;
        cyc = 0;
        while (!done && cyc < 200) begin @(negedge clk); cyc++; end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL done_timeout: done=%b required=1", done);
            return;
        end
        total++;
        if (err !== exp_err || busy !== 1'b0) begin
            bad++;
            $display("FAIL done_state: err=%b busy=%b required err=%b busy=0", err, busy, exp_err);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL done_pulse_width: done=%b required=0", done);
        end
`ifdef ACP_WR_PERF_CNT_EN
        total++;
        if (perf_cycles !== 32'(meas_cnt)) begin
            bad++;
            $display("FAIL perf_cycles: got=%0d required=%0d", perf_cycles, meas_cnt);
        end
`endif
    endtask

    task automatic run_xfer(input logic [31:0] base, input int beats, input int bad_idx, input logic exp_err);
        int nb, miss;
        logic [31:0] a;
        plan(base, beats, bad_idx);
        ddr.delete();
        nb = exp_aw_addr.size();
        start_pulse(base, 16'(beats));
        fork
            drive_stream(beats);
            run_slave(nb);
        join
        wait_done(exp_err);
        miss = 0;
        for (int i = 0; i < beats; i++) begin
            a = {base[31:3], 3'b000} + 32'(8 * i);
            if (!ddr.exists(a)) miss++;
            else if (ddr[a] !== src[i]) miss++;
        end
        total++;
        if (miss != 0 || ddr.size() != beats) begin
            bad++;
            $display("FAIL ddr_contents: wrong=%0d stored=%0d required wrong=0 stored=%0d", miss, ddr.size(), beats);
        end
        src.delete(); exp_w.delete(); exp_aw_addr.delete(); exp_aw_n.delete(); bresp_plan.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        total++;
        if ({busy, done, err, s_tready, m_awvalid, m_wvalid, m_wlast, m_bready} !== 8'h00 ||
            m_awaddr !== 32'h0 || m_awlen !== 4'h0) begin
            bad++;
            $display("FAIL %s: ctl=%b awaddr=%h awlen=%h required ctl=00000000 awaddr=0 awlen=0", tag,
                     {busy, done, err, s_tready, m_awvalid, m_wvalid, m_wlast, m_bready}, m_awaddr, m_awlen);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_values");
        total++;
        if ({m_awsize, m_awburst, m_awcache, m_awuser, m_awprot, m_wstrb, m_awid, m_wid} !==
            {3'b011, 2'b01, 4'b1111, 5'b11111, 3'b000, 8'hFF, 3'd0, 3'd0}) begin
            bad++;
            $display("FAIL constants: size=%b burst=%b cache=%b user=%b prot=%b strb=%h id=%0d/%0d",
                     m_awsize, m_awburst, m_awcache, m_awuser, m_awprot, m_wstrb, m_awid, m_wid);
        end
        rst_n = 1'b1;
        @(negedge clk);
        s_tvalid = 1'b1;
        @(negedge clk);
        total++;
        if (s_tready !== 1'b0) begin
            bad++;
            $display("FAIL idle_tready: s_tready=%b required=0", s_tready);
        end
        s_tvalid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_burst();
        rmode = 0;
        run_xfer(32'h1000_0000, 16, -1, 1'b0);
    endtask

    task automatic test_4k_boundary();
        rmode = 0;
        run_xfer(32'h1000_0FC0, 20, -1, 1'b0);
    endtask

    task automatic test_random_backpressure();
        rmode = 1;
        run_xfer(32'h2000_0000, 40, -1, 1'b0);
        rmode = 0;
    endtask

    task automatic test_zero_beats();
        logic saw_aw;
        start_pulse(32'h5000_0000, 16'd0);
        total++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL zero_done: done=%b busy=%b required done=1 busy=0", done, busy);
        end
        saw_aw = 1'b0;
        @(negedge clk);
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL zero_pulse: done=%b required=0", done);
        end
        repeat (6) begin
            saw_aw = saw_aw | m_awvalid | busy;
            @(negedge clk);
        end
        total++;
        if (saw_aw !== 1'b0) begin
            bad++;
            $display("FAIL zero_no_traffic: awvalid_or_busy_seen=%b required=0", saw_aw);
        end
    endtask

    task automatic test_error();
        rmode = 0;
        run_xfer(32'h3000_0000, 32, 1, 1'b1);
        @(negedge clk);
        total++;
        if (err !== 1'b1) begin
            bad++;
            $display("FAIL err_sticky: err=%b required=1", err);
        end
        run_xfer(32'h3000_1000, 1, -1, 1'b0);
    endtask

    task automatic test_reset_mid();
        int hs, cyc;
        start_pulse(32'h4000_0000, 16'd32);
        s_tvalid = 1'b1; m_awready = 1'b1; m_wready = 1'b1;
        hs = 0; cyc = 0;
        while (hs < 3 && cyc < 500) begin
            s_tdata = {$urandom, $urandom};
            if (m_wvalid && m_wready) hs++;
            @(negedge clk);
            cyc++;
        end
        total++;
        if (hs < 3) begin
            bad++;
            $display("FAIL reset_mid_setup: w_handshakes=%0d required=3", hs);
        end
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset_mid_async");
`ifdef ACP_WR_PERF_CNT_EN
        total++;
        if (perf_cycles !== 32'd0) begin
            bad++;
            $display("FAIL reset_perf: got=%0d required=0", perf_cycles);
        end
`endif
        s_tvalid = 1'b0; m_awready = 1'b0; m_wready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_xfer(32'h4000_0000, 4, -1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_4k_boundary();
        test_random_backpressure();
        test_zero_beats();
        test_error();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
